// File: rtl/parallel_matvec_tiled_if.sv
// Result element stream of parallel_matvec_tiled: one signed element per valid/ready handshake.
// out_sat exists only when PARALLEL_MATVEC_SAT_EN is defined.
interface parallel_matvec_tiled_if #(
  parameter int OUT_BITS = 16,
  parameter int ROW_W    = 4,
  parameter int COL_W    = 5
);
  logic                       out_valid;
  logic                       out_ready;
  logic signed [OUT_BITS-1:0] out_data;
  logic        [ROW_W-1:0]    out_row;
  logic        [COL_W-1:0]    out_col;
  logic                       out_last;
`ifdef PARALLEL_MATVEC_SAT_EN
  logic                       out_sat;
`endif

  modport master (
    output out_valid, out_data, out_row, out_col, out_last,
`ifdef PARALLEL_MATVEC_SAT_EN
    output out_sat,
`endif
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_row, out_col, out_last,
`ifdef PARALLEL_MATVEC_SAT_EN
    input  out_sat,
`endif
    output out_ready
  );
endinterface

// File: rtl/parallel_matvec_tiled.sv
// Tiled signed matrix product OUT = A*B + bias, LANES multipliers per beat, element-serial output stream.
// Optional output clamping with out_sat is enabled by defining PARALLEL_MATVEC_SAT_EN.
module parallel_matvec_tiled #(
  parameter int BITS     = 8,
  parameter int ROWS     = 16,
  parameter int IN_DIM   = 64,
  parameter int COLS     = 32,
  parameter int LANES    = 16,
  parameter int ACC_BITS = 2*BITS + $clog2(IN_DIM) + 1,
  parameter int OUT_BITS = 2*BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [BITS*ROWS*IN_DIM-1:0]   a_flat,
  input  logic [BITS*IN_DIM*COLS-1:0]   b_flat,
  input  logic [BITS*ROWS*COLS-1:0]     bias_flat,
  output logic                          busy,
  output logic                          done,
  parallel_matvec_tiled_if.master       stream
);

  localparam int TILES     = IN_DIM / LANES;
  localparam int ROW_W     = (ROWS  > 1) ? $clog2(ROWS)  : 1;
  localparam int COL_W     = (COLS  > 1) ? $clog2(COLS)  : 1;
  localparam int TILE_W    = (TILES > 1) ? $clog2(TILES) : 1;
  localparam int PROD_BITS = 2*BITS;

  generate
    if (IN_DIM % LANES != 0) begin : g_bad_lanes
      $error("parallel_matvec_tiled: IN_DIM must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, ISSUE, FLUSH, OUT, DONE} state_t;

  state_t state, next_state;

  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [TILE_W-1:0] tile;
  logic [1:0]        flush_cnt;

  logic last_tile, last_flush, last_elem, handshake;

  logic signed [BITS-1:0]      a_lane [LANES];
  logic signed [BITS-1:0]      b_lane [LANES];
  logic signed [PROD_BITS-1:0] prod_d [LANES];
  logic signed [PROD_BITS-1:0] prod_q [LANES];
  logic                        p_valid, p_first;
  logic signed [ACC_BITS-1:0]  tree_sum;
  logic signed [ACC_BITS-1:0]  s_q;
  logic                        s_valid, s_first;
  logic signed [ACC_BITS-1:0]  acc_q;

  logic signed [BITS-1:0]      bias_el;
  logic signed [OUT_BITS-1:0]  data_d, data_q;
  logic [ROW_W-1:0]            row_q;
  logic [COL_W-1:0]            col_q;
  logic                        last_q;

  assign last_tile  = (tile == TILE_W'(TILES - 1));
  assign last_flush = (flush_cnt == 2'd2);
  assign last_elem  = (row == ROW_W'(ROWS - 1)) && (col == COL_W'(COLS - 1));
  assign handshake  = (state == OUT) && stream.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // FLUSH lasts exactly the depth of the P -> S -> accumulator pipeline.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ISSUE;
      ISSUE:   if (last_tile) next_state = FLUSH;
      FLUSH:   if (last_flush) next_state = OUT;
      OUT:     if (handshake) next_state = last_q ? DONE : ISSUE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      col       <= '0;
      tile      <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row  <= '0;
            col  <= '0;
            tile <= '0;
          end
        end
        ISSUE: begin
          tile      <= last_tile ? '0 : tile + 1'b1;
          flush_cnt <= '0;
        end
        FLUSH: flush_cnt <= flush_cnt + 2'd1;
        OUT: begin
          if (handshake && !last_q) begin
            if (col == COL_W'(COLS - 1)) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      a_lane[i] = a_flat[BITS*(int'(row)*IN_DIM + int'(tile)*LANES + i) +: BITS];
      b_lane[i] = b_flat[BITS*((int'(tile)*LANES + i)*COLS + int'(col)) +: BITS];
      prod_d[i] = a_lane[i] * b_lane[i];
    end
  end

  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) tree_sum = tree_sum + ACC_BITS'(prod_q[i]);
  end

  // Valid/first flags travel alongside each beat so the accumulator knows when to load vs add.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      p_valid <= 1'b0;
      p_first <= 1'b0;
      s_q     <= '0;
      s_valid <= 1'b0;
      s_first <= 1'b0;
      acc_q   <= '0;
    end else begin
      p_valid <= (state == ISSUE);
      p_first <= (tile == '0);
      if (state == ISSUE) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
      end
      s_valid <= p_valid;
      s_first <= p_first;
      if (p_valid) s_q <= tree_sum;
      if (s_valid) acc_q <= s_first ? s_q : acc_q + s_q;
    end
  end

  assign bias_el = bias_flat[BITS*(int'(row)*COLS + int'(col)) +: BITS];

`ifdef PARALLEL_MATVEC_SAT_EN
  localparam logic signed [ACC_BITS-1:0] SAT_MAX = ACC_BITS'((2**(OUT_BITS-1)) - 1);
  localparam logic signed [ACC_BITS-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_BITS-1:0] full_sum;
  logic                       sat_d, sat_q;

  always_comb begin
    full_sum = acc_q + ACC_BITS'(bias_el);
    data_d   = full_sum[OUT_BITS-1:0];
    sat_d    = 1'b0;
    if (full_sum > SAT_MAX) begin
      data_d = {1'b0, {(OUT_BITS-1){1'b1}}};
      sat_d  = 1'b1;
    end else if (full_sum < SAT_MIN) begin
      data_d = {1'b1, {(OUT_BITS-1){1'b0}}};
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                             sat_q <= 1'b0;
    else if (state == FLUSH && last_flush) sat_q <= sat_d;
  end

  assign stream.out_sat = sat_q;
`else
  always_comb data_d = OUT_BITS'(acc_q + ACC_BITS'(bias_el));
`endif

  // Output registers only change on the final FLUSH cycle, so they hold through backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      row_q  <= '0;
      col_q  <= '0;
      last_q <= 1'b0;
    end else if (state == FLUSH && last_flush) begin
      data_q <= data_d;
      row_q  <= row;
      col_q  <= col;
      last_q <= last_elem;
    end
  end

  assign busy             = (state != IDLE);
  assign done             = (state == DONE);
  assign stream.out_valid = (state == OUT);
  assign stream.out_data  = data_q;
  assign stream.out_row   = row_q;
  assign stream.out_col   = col_q;
  assign stream.out_last  = last_q;

endmodule

// File: tb/tb_parallel_matvec_tiled.sv
// Self-checking bench for parallel_matvec_tiled: table of uniform-fill runs plus directed
// corner sequences, checked through an expected-element scoreboard queue.
module tb_parallel_matvec_tiled;

  localparam int BITS   = 8;
  localparam int ROWS   = 2;
  localparam int IN_DIM = 8;
  localparam int COLS   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1;
  logic busy0, busy1, done0, done1;
  logic [BITS*ROWS*IN_DIM-1:0] a_flat;
  logic [BITS*IN_DIM*COLS-1:0] b_flat;
  logic [BITS*ROWS*COLS-1:0]   bias_flat;

  parallel_matvec_tiled_if #(.OUT_BITS(16), .ROW_W(1), .COL_W(1)) s0 ();
  parallel_matvec_tiled_if #(.OUT_BITS(16), .ROW_W(1), .COL_W(1)) s1 ();

  parallel_matvec_tiled #(.BITS(BITS), .ROWS(ROWS), .IN_DIM(IN_DIM), .COLS(COLS), .LANES(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .a_flat(a_flat), .b_flat(b_flat),
    .bias_flat(bias_flat), .busy(busy0), .done(done0), .stream(s0)
  );

  parallel_matvec_tiled #(.BITS(BITS), .ROWS(ROWS), .IN_DIM(IN_DIM), .COLS(COLS), .LANES(8)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_flat(a_flat), .b_flat(b_flat),
    .bias_flat(bias_flat), .busy(busy1), .done(done1), .stream(s1)
  );

  typedef struct {
    int data;
    int row;
    int col;
    bit last;
    bit sat;
  } exp_t;

  typedef struct {
    int av;
    int bv;
    int cv;
    int exp_wrap;
    int exp_clamp;
    bit exp_flag;
  } vec_t;

  int   mat_a [ROWS][IN_DIM];
  int   mat_b [IN_DIM][COLS];
  int   mat_c [ROWS][COLS];
  exp_t sb [$];
  vec_t tbl [5];
  int   checks = 0;
  int   fails  = 0;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic pack_flats();
    logic [31:0] v;
    for (int r = 0; r < ROWS; r++)
      for (int k = 0; k < IN_DIM; k++) begin
        v = mat_a[r][k];
        a_flat[BITS*(r*IN_DIM+k) +: BITS] = v[7:0];
      end
    for (int k = 0; k < IN_DIM; k++)
      for (int c = 0; c < COLS; c++) begin
        v = mat_b[k][c];
        b_flat[BITS*(k*COLS+c) +: BITS] = v[7:0];
      end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        v = mat_c[r][c];
        bias_flat[BITS*(r*COLS+c) +: BITS] = v[7:0];
      end
  endtask

  task automatic fill_uniform(input int av, input int bv, input int cv);
    for (int r = 0; r < ROWS; r++) for (int k = 0; k < IN_DIM; k++) mat_a[r][k] = av;
    for (int k = 0; k < IN_DIM; k++) for (int c = 0; c < COLS; c++) mat_b[k][c] = bv;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mat_c[r][c] = cv;
    pack_flats();
  endtask

  function automatic exp_t model(input int r, input int c);
    exp_t        e;
    int          sum;
    logic [31:0] s;
    logic [15:0] w;
    sum = mat_c[r][c];
    for (int k = 0; k < IN_DIM; k++) sum += mat_a[r][k] * mat_b[k][c];
    e.row  = r;
    e.col  = c;
    e.last = (r == ROWS-1) && (c == COLS-1);
    e.sat  = 1'b0;
`ifdef PARALLEL_MATVEC_SAT_EN
    if (sum > 32767) begin
      e.data = 32767;
      e.sat  = 1'b1;
    end else if (sum < -32768) begin
      e.data = -32768;
      e.sat  = 1'b1;
    end else begin
      e.data = sum;
    end
`else
    s = sum;
    w = s[15:0];
    e.data = int'($signed(w));
`endif
    return e;
  endfunction

  task automatic push_uniform(input int data, input bit sat);
    exp_t e;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        e.data = data;
        e.row  = r;
        e.col  = c;
        e.last = (r == ROWS-1) && (c == COLS-1);
        e.sat  = sat;
        sb.push_back(e);
      end
  endtask

  task automatic set_start(input int sel, input logic val);
    if (sel == 0) start0 = val;
    else          start1 = val;
  endtask

  task automatic set_ready(input int sel, input logic val);
    if (sel == 0) s0.out_ready = val;
    else          s1.out_ready = val;
  endtask

  task automatic sample(input int sel, output logic v, output logic signed [15:0] d,
                        output logic r, output logic c, output logic l, output logic s,
                        output logic bz, output logic dn);
    if (sel == 0) begin
      v = s0.out_valid; d = s0.out_data; r = s0.out_row; c = s0.out_col; l = s0.out_last;
      bz = busy0; dn = done0;
`ifdef PARALLEL_MATVEC_SAT_EN
      s = s0.out_sat;
`else
      s = 1'b0;
`endif
    end else begin
      v = s1.out_valid; d = s1.out_data; r = s1.out_row; c = s1.out_col; l = s1.out_last;
      bz = busy1; dn = done1;
`ifdef PARALLEL_MATVEC_SAT_EN
      s = s1.out_sat;
`else
      s = 1'b0;
`endif
    end
  endtask

  // Cycle 0 is the negedge where start is raised; ISSUE is first observed at cycle 1.
  task automatic applyStimulus(input int sel, input int stall_idx, input int stall_len,
                               input bit mid_pulse, output int first_valid, output int done_at,
                               output int last_hs, output int n_elems, output int n_done);
    logic v, r, c, l, s, bz, dn;
    logic signed [15:0] d;
    logic signed [15:0] snap_d;
    logic snap_r, snap_c, snap_l;
    int cyc, stalled, post;
    exp_t e;
    first_valid = -1; done_at = -1; last_hs = -1; n_elems = 0; n_done = 0;
    cyc = 0; stalled = 0; post = 0;
    snap_d = '0; snap_r = 1'b0; snap_c = 1'b0; snap_l = 1'b0;
    @(negedge clk);
    set_start(sel, 1'b1);
    set_ready(sel, 1'b1);
    while (cyc < 300 && post < 4) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) set_start(sel, 1'b0);
      if (mid_pulse && cyc == 3) set_start(sel, 1'b1);
      if (mid_pulse && cyc == 4) set_start(sel, 1'b0);
      sample(sel, v, d, r, c, l, s, bz, dn);
      if (dn) begin
        n_done++;
        if (done_at < 0) done_at = cyc;
      end
      if (done_at >= 0 && cyc > done_at) post++;
      if (v) begin
        if (first_valid < 0) first_valid = cyc;
        if (n_elems == stall_idx && stalled < stall_len) begin
          if (stalled == 0) begin
            snap_d = d; snap_r = r; snap_c = c; snap_l = l;
          end else begin
            checkOutput("stall data stable", d, snap_d);
            checkOutput("stall row stable", r, snap_r);
            checkOutput("stall col stable", c, snap_c);
            checkOutput("stall last stable", l, snap_l);
            checkOutput("stall busy", bz, 1);
          end
          set_ready(sel, 1'b0);
          stalled++;
        end else begin
          set_ready(sel, 1'b1);
          if (sb.size() == 0) begin
            checkOutput("unexpected element", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("element data", d, e.data);
            checkOutput("element row", r, e.row);
            checkOutput("element col", c, e.col);
            checkOutput("element last", l, e.last);
`ifdef PARALLEL_MATVEC_SAT_EN
            checkOutput("element sat", s, e.sat);
`endif
          end
          last_hs = cyc;
          n_elems++;
        end
      end
    end
    if (done_at < 0) checkOutput("timeout waiting for done", 0, 1);
    set_ready(sel, 1'b1);
  endtask

  task automatic check_run(input string tag, input int lat_req, input int run_req,
                           input int fv, input int da, input int lh, input int ne, input int nd);
    checkOutput({tag, " latency"}, fv - 1, lat_req);
    checkOutput({tag, " done timing"}, da - 1, run_req);
    checkOutput({tag, " done after last handshake"}, da - lh, 1);
    checkOutput({tag, " element count"}, ne, 4);
    checkOutput({tag, " done pulses"}, nd, 1);
    checkOutput({tag, " scoreboard drained"}, sb.size(), 0);
  endtask

  initial begin
    logic v, r, c, l, s, bz, dn;
    logic signed [15:0] d;
    int fv, da, lh, ne, nd;
    exp_t e;

    tbl[0] = '{av:    1, bv:    1, cv:    0, exp_wrap:     8, exp_clamp:      8, exp_flag: 1'b0};
    tbl[1] = '{av: -128, bv: -128, cv:  127, exp_wrap:   127, exp_clamp:  32767, exp_flag: 1'b1};
    tbl[2] = '{av:    2, bv:   -3, cv:    5, exp_wrap:   -43, exp_clamp:    -43, exp_flag: 1'b0};
    tbl[3] = '{av:  127, bv:  127, cv: -128, exp_wrap: -2168, exp_clamp:  32767, exp_flag: 1'b1};
    tbl[4] = '{av: -128, bv:  127, cv: -128, exp_wrap:   896, exp_clamp: -32768, exp_flag: 1'b1};

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    s0.out_ready = 1'b1; s1.out_ready = 1'b1;
    fill_uniform(0, 0, 0);
    repeat (3) @(negedge clk);
    sample(0, v, d, r, c, l, s, bz, dn);
    checkOutput("reset out_valid", v, 0);
    checkOutput("reset busy", bz, 0);
    checkOutput("reset done", dn, 0);
    checkOutput("reset out_last", l, 0);
    checkOutput("reset out_data", d, 0);
    checkOutput("reset out_row", r, 0);
    checkOutput("reset out_col", c, 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      fill_uniform(tbl[i].av, tbl[i].bv, tbl[i].cv);
`ifdef PARALLEL_MATVEC_SAT_EN
      push_uniform(tbl[i].exp_clamp, tbl[i].exp_flag);
`else
      push_uniform(tbl[i].exp_wrap, 1'b0);
`endif
      applyStimulus(0, -1, 0, 1'b0, fv, da, lh, ne, nd);
      check_run($sformatf("table %0d", i), 5, 24, fv, da, lh, ne, nd);
    end

    $display("[TB] directed: mixed-sign dot product");
    for (int k = 0; k < IN_DIM; k++) begin
      mat_a[0][k] = k + 1;
      mat_a[1][k] = k - 4;
      mat_b[k][0] = (k % 2 == 0) ? 1 : -1;
      mat_b[k][1] = 3*k - 10;
    end
    mat_c[0][0] = -3; mat_c[0][1] = 7; mat_c[1][0] = -20; mat_c[1][1] = 100;
    pack_flats();
    e = model(0, 0);
    e.data = -7;
    sb.push_back(e);
    sb.push_back(model(0, 1));
    sb.push_back(model(1, 0));
    sb.push_back(model(1, 1));
    applyStimulus(0, -1, 0, 1'b0, fv, da, lh, ne, nd);
    check_run("mixed", 5, 24, fv, da, lh, ne, nd);

    $display("[TB] directed: 10-cycle backpressure on element (0,1)");
    fill_uniform(1, 1, 0);
    push_uniform(8, 1'b0);
    applyStimulus(0, 1, 10, 1'b0, fv, da, lh, ne, nd);
    check_run("stall", 5, 34, fv, da, lh, ne, nd);

    $display("[TB] directed: reset during second ISSUE beat");
    fill_uniform(1, 1, 0);
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    sample(0, v, d, r, c, l, s, bz, dn);
    checkOutput("mid reset out_valid", v, 0);
    checkOutput("mid reset busy", bz, 0);
    checkOutput("mid reset done", dn, 0);
    checkOutput("mid reset out_data", d, 0);
    rst = 1'b0;
    push_uniform(8, 1'b0);
    applyStimulus(0, -1, 0, 1'b0, fv, da, lh, ne, nd);
    check_run("after reset", 5, 24, fv, da, lh, ne, nd);

    $display("[TB] directed: single-tile instance, start pulsed while busy");
    fill_uniform(1, 1, 0);
    push_uniform(8, 1'b0);
    applyStimulus(1, -1, 0, 1'b1, fv, da, lh, ne, nd);
    check_run("single tile", 4, 20, fv, da, lh, ne, nd);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
